// File: rtl/uart_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio_bridge
// Description : MMIO front end for a full-duplex UART: TX request FSM,
//               RX byte FIFO and a status register with sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  input  logic        tx_busy_in,
  input  logic        rx_valid_in,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_parity_err_in,
  output logic        rx_clr,
  output logic        irq_rx
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [CNT_W-1:0]   c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0]   c_cnt_full = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_idle      = 2'd0;
  localparam logic [1:0] c_start     = 2'd1;
  localparam logic [1:0] c_wait_busy = 2'd2;
  localparam logic [1:0] c_wait_done = 2'd3;

  logic [1:0]         r_state;
  logic [7:0]         r_tx_data;
  logic               r_tx_drop;
  logic               r_parity_err;
  logic               r_rx_overrun;
  logic               r_rx_clr;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;

  logic w_tx_wr, w_st_wr, w_rx_rd;
  logic w_empty, w_full, w_pop, w_push;
  logic w_ovr_set, w_par_set, w_drop_set;
  logic w_unused;

  assign w_tx_wr = sel & we & (addr == 4'h0);
  assign w_st_wr = sel & we & (addr == 4'h8);
  assign w_rx_rd = sel & re & (addr == 4'h4);

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == c_cnt_full);
  assign w_pop   = w_rx_rd & ~w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push  = rx_valid_in & (~w_full | w_pop);

  assign w_ovr_set  = rx_valid_in & w_full & ~w_pop;
  assign w_par_set  = rx_valid_in & rx_parity_err_in;
  assign w_drop_set = w_tx_wr & (r_state != c_idle);

  assign w_unused = &{1'b0, wdata[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_idle;
      r_tx_data <= 8'h00;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_tx_wr) begin
            r_tx_data <= wdata[7:0];
            r_state   <= c_start;
          end
        end
        c_start:     r_state <= c_wait_busy;
        c_wait_busy: if (tx_busy_in) r_state <= c_wait_done;
        c_wait_done: if (!tx_busy_in) r_state <= c_idle;
        default:     r_state <= c_idle;
      endcase
    end
  end

  // Sticky flags: a set event wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_drop    <= 1'b0;
      r_parity_err <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rx_clr     <= 1'b0;
    end else begin
      r_tx_drop    <= w_drop_set | (r_tx_drop    & ~(w_st_wr & wdata[4]));
      r_parity_err <= w_par_set  | (r_parity_err & ~(w_st_wr & wdata[3]));
      r_rx_overrun <= w_ovr_set  | (r_rx_overrun & ~(w_st_wr & wdata[2]));
      r_rx_clr     <= rx_valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rx_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_cnt_one;
        2'b01:   r_cnt <= r_cnt - c_cnt_one;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (addr)
        4'h0: rdata[7:0] = r_tx_data;
        4'h4: if (!w_empty) rdata[7:0] = r_mem[r_rd_ptr];
        4'h8: begin
          rdata[8 +: CNT_W] = r_cnt;
          rdata[4]          = r_tx_drop;
          rdata[3]          = r_parity_err;
          rdata[2]          = r_rx_overrun;
          rdata[1]          = (r_state != c_idle);
          rdata[0]          = ~w_empty;
        end
        default: rdata = 32'h0;
      endcase
    end
  end

  assign tx_send = (r_state == c_start);
  assign tx_data = r_tx_data;
  assign rx_clr  = r_rx_clr;
  assign irq_rx  = ~w_empty;

endmodule
`default_nettype wire
